// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory.
// Port 0 carries instruction-cache line requests and port 1 carries data-cache
// line requests. Each granted transaction forwards the owner's request to
// memory until mem_ack_i arrives. A one-cycle RELEASE bubble then follows
// before the arbiter can grant again.
//
// Handshake: a requester raises pN_enable_i and holds it, along with its
// address, data and write qualifier, until pN_ack_o pulses for one cycle.
// The memory holds mem_ack_i high for one cycle to complete the request
// driven on mem_enable_o. The read data on pN_data_o is only meaningful in
// the cycle where pN_ack_o is high.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // instruction-cache port
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,
    // data-cache port
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,
    // shared memory
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    // status and debug visibility
    output logic              busy_o,
    output logic [1:0]        dbg_state_o,
    output logic              dbg_last_grant_o
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GRANT0  = 2'b01;
    localparam logic [1:0] GRANT1  = 2'b10;
    localparam logic [1:0] RELEASE = 2'b11;

    logic [1:0] state_q;
    logic [1:0] state_nxt;
    logic       last_grant_q;
    logic       last_grant_nxt;

    // State and round-robin pointer registers. The pointer resets to 1 so
    // that port 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_nxt;
            last_grant_q <= last_grant_nxt;
        end
    end

    // Next-state logic. Grants happen only from IDLE. A granted port keeps the
    // memory until mem_ack_i, even if its enable drops early.
    always_comb begin
        state_nxt      = state_q;
        last_grant_nxt = last_grant_q;
        case (state_q)
            IDLE: begin
                if (p0_enable_i && p1_enable_i) begin
                    if (last_grant_q) begin
                        state_nxt      = GRANT0;
                        last_grant_nxt = 1'b0;
                    end else begin
                        state_nxt      = GRANT1;
                        last_grant_nxt = 1'b1;
                    end
                end else if (p0_enable_i) begin
                    state_nxt      = GRANT0;
                    last_grant_nxt = 1'b0;
                end else if (p1_enable_i) begin
                    state_nxt      = GRANT1;
                    last_grant_nxt = 1'b1;
                end
            end
            GRANT0: begin
                if (mem_ack_i) state_nxt = RELEASE;
            end
            GRANT1: begin
                if (mem_ack_i) state_nxt = RELEASE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory-side mux. This forwards the granted port's request and drives
    // all zeros when no port is granted.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            GRANT0: begin
                mem_enable_o = p0_enable_i;
                mem_write_o  = p0_write_i;
                mem_addr_o   = p0_addr_i;
                mem_data_o   = p0_data_i;
            end
            GRANT1: begin
                mem_enable_o = p1_enable_i;
                mem_write_o  = p1_write_i;
                mem_addr_o   = p1_addr_i;
                mem_data_o   = p1_data_i;
            end
            default: begin
                mem_enable_o = 1'b0;
            end
        endcase
    end

    // Requester-side responses. The memory ack is routed to the granted port
    // only. Read data is broadcast to both ports, except during reset, when
    // every output is forced low.
    always_comb begin
        p0_ack_o  = (state_q == GRANT0) && mem_ack_i;
        p1_ack_o  = (state_q == GRANT1) && mem_ack_i;
        p0_data_o = rst_i ? mem_data_i : '0;
        p1_data_o = rst_i ? mem_data_i : '0;
    end

    // Status and debug outputs.
    always_comb begin
        busy_o           = (state_q != IDLE);
        dbg_state_o      = state_q;
        dbg_last_grant_o = last_grant_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. A cycle table drives the inputs directly. Then
// several sequences run against a memory model that acks 10 cycles after
// mem_enable_o rises.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

    localparam logic [1:0] ST_I  = 2'b00;
    localparam logic [1:0] ST_G0 = 2'b01;
    localparam logic [1:0] ST_G1 = 2'b10;
    localparam logic [1:0] ST_R  = 2'b11;

    localparam logic [ADDR_W-1:0] P0_ADDR  = 32'h0000_0100;
    localparam logic [ADDR_W-1:0] P1_ADDR  = 32'h0000_0200;
    localparam logic [DATA_W-1:0] P0_DATA  = {32{8'h11}};
    localparam logic [DATA_W-1:0] P1_DATA  = {32{8'h22}};
    localparam logic [DATA_W-1:0] MEM_DATA = {32{8'h33}};
    localparam logic [DATA_W-1:0] A5_DATA  = {32{8'hA5}};

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              p0_enable_i = 1'b0, p0_write_i = 1'b0;
    logic [ADDR_W-1:0] p0_addr_i = '0;
    logic [DATA_W-1:0] p0_data_i = '0;
    logic              p0_ack_o;
    logic [DATA_W-1:0] p0_data_o;
    logic              p1_enable_i = 1'b0, p1_write_i = 1'b0;
    logic [ADDR_W-1:0] p1_addr_i = '0;
    logic [DATA_W-1:0] p1_data_i = '0;
    logic              p1_ack_o;
    logic [DATA_W-1:0] p1_data_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i = 1'b0;
    logic [DATA_W-1:0] mem_data_i = MEM_DATA;
    logic              busy_o;
    logic [1:0]        dbg_state_o;
    logic              dbg_last_grant_o;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i),
        .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i),
        .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .busy_o(busy_o), .dbg_state_o(dbg_state_o),
        .dbg_last_grant_o(dbg_last_grant_o)
    );

    // ---------------- clock / bookkeeping ----------------
    initial forever #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    bit model_on = 1'b0;
    int mem_cnt  = 0;

    initial forever begin
        @(posedge clk_i);
        #1;
        if (model_on) begin
            if (mem_enable_o && !mem_ack_i) begin
                mem_cnt++;
                if (mem_cnt == 10) mem_ack_i = 1'b1;
            end else begin
                mem_ack_i = 1'b0;
                mem_cnt   = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    bit prev_en = 1'b0;
    int rise_q[$];
    int fall_q[$];
    logic [0:0] exp_q[$];   // expected grant order
    logic [0:0] grant_q[$]; // observed grant order
    int a0_cnt = 0, a1_cnt = 0;
    bit chk_wr = 1'b0;
    int wr_seen = 0;

    initial forever begin
        @(negedge clk_i);
        cyc++;
        if (mem_enable_o && !prev_en) begin
            rise_q.push_back(cyc);
            grant_q.push_back(dbg_state_o == ST_G1);
        end
        if (!mem_enable_o && prev_en) fall_q.push_back(cyc);
        prev_en = mem_enable_o;
        if (p0_ack_o) a0_cnt++;
        if (p1_ack_o) a1_cnt++;
        chk("ack_exclusive", DATA_W'(p0_ack_o & p1_ack_o), '0);
        chk("p0_data_o", p0_data_o, rst_i ? mem_data_i : '0);
        chk("p1_data_o", p1_data_o, rst_i ? mem_data_i : '0);
        if (chk_wr && dbg_state_o == ST_G1) begin
            wr_seen++;
            chk("wr_mem_write", DATA_W'(mem_write_o), DATA_W'(1'b1));
            chk("wr_mem_data", mem_data_o, A5_DATA);
            chk("wr_mem_addr", DATA_W'(mem_addr_o), DATA_W'(32'h20));
        end
    end

    // The watchdog ends a hung run with a FAIL line.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic clear_log();
        rise_q.delete();
        fall_q.delete();
        grant_q.delete();
        exp_q.delete();
        a0_cnt = 0;
        a1_cnt = 0;
    endtask

    task automatic do_reset(input bit check_outputs);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        if (check_outputs) begin
            chk("rst_mem_enable", DATA_W'(mem_enable_o), '0);
            chk("rst_mem_write", DATA_W'(mem_write_o), '0);
            chk("rst_mem_addr", DATA_W'(mem_addr_o), '0);
            chk("rst_mem_data", mem_data_o, '0);
            chk("rst_p0_ack", DATA_W'(p0_ack_o), '0);
            chk("rst_p1_ack", DATA_W'(p1_ack_o), '0);
            chk("rst_p0_data", p0_data_o, '0);
            chk("rst_busy", DATA_W'(busy_o), '0);
            chk("rst_state", DATA_W'(dbg_state_o), DATA_W'(ST_I));
            chk("rst_last_grant", DATA_W'(dbg_last_grant_o), DATA_W'(1'b1));
        end
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic drive_port(input int port, input logic en, input logic wr,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if (port == 0) begin
            p0_enable_i = en;
            p0_write_i  = wr;
            p0_addr_i   = addr;
            p0_data_i   = data;
        end else begin
            p1_enable_i = en;
            p1_write_i  = wr;
            p1_addr_i   = addr;
            p1_data_i   = data;
        end
    endtask

    // Raises a request, waits a bounded time for the ack, then drops the
    // enable in the cycle after the ack.
    task automatic request(input int port, input logic wr,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bit got;
        got = 1'b0;
        @(posedge clk_i);
        #1;
        drive_port(port, 1'b1, wr, addr, data);
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk_i);
            got = (port == 0) ? p0_ack_o : p1_ack_o;
        end
        chk("request_ack_seen", DATA_W'(got), DATA_W'(1'b1));
        @(posedge clk_i);
        #1;
        drive_port(port, 1'b0, 1'b0, addr, data);
    endtask

    // ---------------- cycle table ----------------
    typedef struct packed {
        logic       p0_en, p0_wr, p1_en, p1_wr, ack;
        logic [1:0] st;
        logic       m_en, m_wr;
        logic [1:0] sel;   // 0: none, 1: port 0, 2: port 1
        logic       a0, a1, busy;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mkv(bit p0e, bit p0w, bit p1e, bit p1w, bit ack,
                                 bit [1:0] st, bit me, bit mw, bit [1:0] sel,
                                 bit a0, bit a1, bit busy);
        vec_t v;
        v = '{p0e, p0w, p1e, p1w, ack, st, me, mw, sel, a0, a1, busy};
        return v;
    endfunction

    initial begin
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        bit got;
        bit was_granted;

        // The state field holds the state each row is expected to observe.
        // It follows from the inputs of the previous row.
        tbl[0]  = mkv(0,0,0,0,0, ST_I , 0,0,0, 0,0,0);
        tbl[1]  = mkv(1,0,0,0,0, ST_I , 0,0,0, 0,0,0);
        tbl[2]  = mkv(1,0,1,0,0, ST_G0, 1,0,1, 0,0,1);
        tbl[3]  = mkv(1,1,1,0,1, ST_G0, 1,1,1, 1,0,1);
        tbl[4]  = mkv(1,0,1,0,1, ST_R , 0,0,0, 0,0,1);
        tbl[5]  = mkv(1,0,1,0,0, ST_I , 0,0,0, 0,0,0);
        tbl[6]  = mkv(1,0,1,1,0, ST_G1, 1,1,2, 0,0,1);
        tbl[7]  = mkv(1,0,0,0,0, ST_G1, 0,0,2, 0,0,1);
        tbl[8]  = mkv(1,0,1,0,1, ST_G1, 1,0,2, 0,1,1);
        tbl[9]  = mkv(1,0,1,0,0, ST_R , 0,0,0, 0,0,1);
        tbl[10] = mkv(1,0,1,0,0, ST_I , 0,0,0, 0,0,0);
        tbl[11] = mkv(0,0,0,0,1, ST_G0, 0,0,1, 1,0,1);
        tbl[12] = mkv(0,0,0,0,1, ST_R , 0,0,0, 0,0,1);
        tbl[13] = mkv(0,0,0,0,1, ST_I , 0,0,0, 0,0,0);
        tbl[14] = mkv(0,0,0,0,1, ST_I , 0,0,0, 0,0,0);

        do_reset(1'b1);

        p0_addr_i = P0_ADDR;
        p0_data_i = P0_DATA;
        p1_addr_i = P1_ADDR;
        p1_data_i = P1_DATA;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_i);
            #1;
            p0_enable_i = tbl[i].p0_en;
            p0_write_i  = tbl[i].p0_wr;
            p1_enable_i = tbl[i].p1_en;
            p1_write_i  = tbl[i].p1_wr;
            mem_ack_i   = tbl[i].ack;
            @(negedge clk_i);
            e_addr = (tbl[i].sel == 2'd1) ? P0_ADDR : (tbl[i].sel == 2'd2) ? P1_ADDR : '0;
            e_data = (tbl[i].sel == 2'd1) ? P0_DATA : (tbl[i].sel == 2'd2) ? P1_DATA : '0;
            chk($sformatf("v%0d_state", i), DATA_W'(dbg_state_o), DATA_W'(tbl[i].st));
            chk($sformatf("v%0d_mem_enable", i), DATA_W'(mem_enable_o), DATA_W'(tbl[i].m_en));
            chk($sformatf("v%0d_mem_write", i), DATA_W'(mem_write_o), DATA_W'(tbl[i].m_wr));
            chk($sformatf("v%0d_mem_addr", i), DATA_W'(mem_addr_o), DATA_W'(e_addr));
            chk($sformatf("v%0d_mem_data", i), mem_data_o, e_data);
            chk($sformatf("v%0d_p0_ack", i), DATA_W'(p0_ack_o), DATA_W'(tbl[i].a0));
            chk($sformatf("v%0d_p1_ack", i), DATA_W'(p1_ack_o), DATA_W'(tbl[i].a1));
            chk($sformatf("v%0d_busy", i), DATA_W'(busy_o), DATA_W'(tbl[i].busy));
        end
        @(posedge clk_i);
        #1;
        p0_enable_i = 1'b0;
        p1_enable_i = 1'b0;
        p0_write_i  = 1'b0;
        p1_write_i  = 1'b0;
        mem_ack_i   = 1'b0;
        model_on    = 1'b1;

        // A single p1 read: one-cycle grant latency, one p1 ack, no p0 ack.
        do_reset(1'b0);
        clear_log();
        @(posedge clk_i);
        #1;
        drive_port(1, 1'b1, 1'b0, 32'h0000_0400, '0);
        @(negedge clk_i);
        chk("rd_not_yet_granted", DATA_W'(mem_enable_o), '0);
        @(negedge clk_i);
        chk("rd_grant_enable", DATA_W'(mem_enable_o), DATA_W'(1'b1));
        chk("rd_grant_addr", DATA_W'(mem_addr_o), DATA_W'(32'h400));
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk_i);
            got = p1_ack_o;
        end
        chk("rd_ack_seen", DATA_W'(got), DATA_W'(1'b1));
        @(posedge clk_i);
        #1;
        drive_port(1, 1'b0, 1'b0, '0, '0);
        repeat (5) @(negedge clk_i);
        chk("rd_p1_ack_count", DATA_W'(a1_cnt), DATA_W'(1));
        chk("rd_p0_ack_count", DATA_W'(a0_cnt), DATA_W'(0));
        chk("rd_no_regrant", DATA_W'(rise_q.size()), DATA_W'(1));

        // A simultaneous request from both ports: p0 first, then a two-cycle gap, then p1.
        do_reset(1'b0);
        clear_log();
        fork
            request(0, 1'b0, P0_ADDR, '0);
            request(1, 1'b0, P1_ADDR, '0);
        join
        repeat (3) @(negedge clk_i);
        exp_q = '{1'b0, 1'b1};
        chk("tie_grant_count", DATA_W'(grant_q.size()), DATA_W'(2));
        for (int i = 0; i < 2 && i < grant_q.size(); i++)
            chk($sformatf("tie_grant%0d", i), DATA_W'(grant_q[i]), DATA_W'(exp_q[i]));
        if (rise_q.size() >= 2 && fall_q.size() >= 1)
            chk("tie_gap_cycles", DATA_W'(rise_q[1] - fall_q[0]), DATA_W'(2));
        else
            chk("tie_gap_edges", DATA_W'(rise_q.size()), DATA_W'(2));

        // With both ports requesting continuously, grants alternate strictly.
        do_reset(1'b0);
        clear_log();
        fork
            begin
                for (int k = 0; k < 3; k++) request(0, 1'b0, P0_ADDR, '0);
            end
            begin
                for (int k = 0; k < 3; k++) request(1, 1'b0, P1_ADDR, '0);
            end
        join
        repeat (3) @(negedge clk_i);
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        chk("rr_grant_count", DATA_W'(grant_q.size()), DATA_W'(6));
        for (int i = 0; i < 6 && i < grant_q.size(); i++)
            chk($sformatf("rr_grant%0d", i), DATA_W'(grant_q[i]), DATA_W'(exp_q[i]));

        // A p1 write forwards its data and write qualifier through the whole grant.
        do_reset(1'b0);
        clear_log();
        wr_seen = 0;
        chk_wr  = 1'b1;
        request(1, 1'b1, 32'h20, A5_DATA);
        chk_wr = 1'b0;
        chk("wr_grant_cycles", DATA_W'(wr_seen >= 10), DATA_W'(1'b1));

        // Reset 4 cycles into GRANT0 aborts the transaction without an ack.
        // The request still pending afterwards is then served normally.
        do_reset(1'b0);
        clear_log();
        @(posedge clk_i);
        #1;
        drive_port(0, 1'b1, 1'b0, P0_ADDR, '0);
        was_granted = 1'b0;
        for (int c = 0; c < 20 && !was_granted; c++) begin
            @(negedge clk_i);
            was_granted = (dbg_state_o == ST_G0);
        end
        chk("abort_granted", DATA_W'(was_granted), DATA_W'(1'b1));
        repeat (4) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("abort_mem_enable", DATA_W'(mem_enable_o), '0);
        chk("abort_mem_addr", DATA_W'(mem_addr_o), '0);
        chk("abort_p0_ack", DATA_W'(p0_ack_o), '0);
        chk("abort_busy", DATA_W'(busy_o), '0);
        chk("abort_state", DATA_W'(dbg_state_o), DATA_W'(ST_I));
        chk("abort_p0_data", p0_data_o, '0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        chk("abort_no_ack_before", DATA_W'(a0_cnt), DATA_W'(0));
        @(negedge clk_i);
        chk("abort_idle_after", DATA_W'(dbg_state_o), DATA_W'(ST_I));
        @(negedge clk_i);
        chk("abort_regrant", DATA_W'(mem_enable_o), DATA_W'(1'b1));
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk_i);
            got = p0_ack_o;
        end
        chk("abort_ack_after", DATA_W'(got), DATA_W'(1'b1));
        @(posedge clk_i);
        #1;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk_i);
        chk("abort_ack_count", DATA_W'(a0_cnt), DATA_W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001: Parameter ADDR_W, default 32: width of every address port.
- REQ-002: Parameter DATA_W, default 256: width of every memory data port, one cache line.
- REQ-003: clk_i  input  1: single clock; all state updates on the rising edge.
- REQ-004: rst_i  input  1: asynchronous, active-low reset.
- REQ-005: p0_enable_i / p0_write_i  input  1/1: instruction-cache port; request held high until acknowledged, and write qualifier.
- REQ-006: p0_addr_i / p0_data_i  input  ADDR_W/DATA_W: port-0 line address and write data.
- REQ-007: p0_ack_o / p0_data_o  output  1/DATA_W: port-0 completion pulse and read data.
- REQ-008: p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o: data-cache port, identical to port 0.
- REQ-009: mem_enable_o / mem_write_o  output  1/1: request and write qualifier to the shared data memory.
- REQ-010: mem_addr_o / mem_data_o  output  ADDR_W/DATA_W: memory address and write data.
- REQ-011: mem_ack_i / mem_data_i  input  1/DATA_W: memory completion pulse and read data.
- REQ-012: busy_o  output  1: high in every state other than IDLE.

Function
- REQ-013: FSM states SHALL be IDLE, GRANT0, GRANT1 and RELEASE, held in a registered state vector.
- REQ-014: A one-bit register last_grant SHALL record the port that was granted most recently.
- REQ-015: In IDLE with only pN_enable_i high, the next state SHALL be GRANTN.
- REQ-016: In IDLE with both enables high, the next state SHALL be GRANT for the port not equal to last_grant (round-robin).
- REQ-017: last_grant SHALL update on the IDLE->GRANTN edge.
- REQ-018: Grant latency SHALL be exactly 1 cycle from enable sampled high in IDLE to mem_enable_o high.
- REQ-019: In GRANTN, mem_enable_o, mem_write_o, mem_addr_o and mem_data_o SHALL equal port N's inputs combinationally.
- REQ-020: In GRANTN, the other port's inputs SHALL be ignored.
- REQ-021: In IDLE and RELEASE, mem_enable_o and mem_write_o SHALL be 0, and mem_addr_o and mem_data_o SHALL be all-zero.
- REQ-022: In GRANTN with mem_ack_i high, pN_ack_o SHALL equal 1 in that same cycle, combinationally, and the next state SHALL be RELEASE.
- REQ-023: pX_ack_o SHALL be 0 for the non-granted port at all times.
- REQ-024: pX_ack_o SHALL be 0 for both ports in IDLE and RELEASE, regardless of mem_ack_i.
- REQ-025: p0_data_o and p1_data_o SHALL both equal mem_data_i at all times; only the ack qualifies the data.
- REQ-026: RELEASE SHALL last exactly 1 cycle and then go unconditionally to IDLE.
- REQ-027: The RELEASE bubble SHALL prevent re-grant to a requester whose enable is still high in the cycle after its ack.
- REQ-028: In GRANTN with mem_ack_i low, the state SHALL stay GRANTN; there SHALL be no timeout.
- REQ-029: If pN_enable_i drops while in GRANTN, it is a protocol violation; the block SHALL forward the low enable and stay in GRANTN until mem_ack_i.
- REQ-030: mem_ack_i high in IDLE or RELEASE SHALL be ignored and SHALL NOT change state.
- REQ-031: A single requester SHALL NOT wait longer than one full transaction of the other port plus 2 cycles after its request is sampled.

Reset
- REQ-032: While rst_i is low, the state SHALL be IDLE and last_grant SHALL be 1, so port 0 wins the first tie.
- REQ-033: While rst_i is low, all outputs SHALL be 0 and busy_o SHALL be 0.
- REQ-034: Reset asserted mid-transaction SHALL abort immediately with no ack.
- REQ-035: After reset deasserts, the block SHALL restart from IDLE.

Verification
- REQ-036: Memory model acks 10 cycles after enable rises; after reset, p1 read of addr 0x0000_0400 -> mem_addr_o=0x400 one cycle later, p1_ack_o pulses once, p0_ack_o stays 0.
- REQ-037: After reset, p0 and p1 raise enable in the same cycle -> p0 served first, then p1, with exactly one RELEASE plus one IDLE cycle between the two mem_enable_o pulses.
- REQ-038: Both ports request continuously for 6 transactions -> grant order p0,p1,p0,p1,p0,p1.
- REQ-039: p1 write of data 0xA5..A5 to addr 0x20 -> mem_write_o=1 and mem_data_o=0xA5..A5 throughout GRANT1.
- REQ-040: Spurious mem_ack_i in IDLE -> no ack output, state unchanged.
- REQ-041: rst_i pulled low 4 cycles into GRANT0 -> all outputs 0 asynchronously, no ack; after release, a new p0 request is granted normally.
